// File: rtl/bitrev_stream.sv
`timescale 1ns/1ps
// bitrev_stream
// Streaming bit permuter with a 2-entry output buffer and valid/ready flow
// control. Every accepted word is permuted according to the mode sampled
// with that word (bit, nibble or byte reverse, or pass-through). The result
// is stored together with its mode, so the consumer can tell how each word
// was produced.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   in_valid  producer has a beat
//   in_ready  block can accept a beat (registered)
//   in_data   word to permute
//   in_mode   0 bit reverse, 1 nibble reverse, 2 byte reverse, 3 pass
//   out_valid head of buffer valid (registered)
//   out_ready consumer accepts head
//   out_data  permuted word at head
//   out_mode  mode the head word was permuted with
//   level     buffer occupancy, 0..2
//   beat_cnt  accepted input beats, modulo 2^CNT_W
module bitrev_stream #(
  parameter int W     = 8,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [1:0]       out_mode,
  output logic [1:0]       level,
  output logic [CNT_W-1:0] beat_cnt
);

  function automatic logic [W-1:0] permute(input logic [W-1:0] d,
                                           input logic [1:0]   m);
    logic [W-1:0] r;
    r = d;
    case (m)
      2'd0: for (int j = 0; j < W; j++) r[j] = d[W-1-j];
      2'd1: for (int k = 0; k < W/4; k++) r[4*k +: 4] = d[4*(W/4-1-k) +: 4];
      2'd2: for (int k = 0; k < W/8; k++) r[8*k +: 8] = d[8*(W/8-1-k) +: 8];
      default: r = d;
    endcase
    return r;
  endfunction

  logic [W-1:0]     r_data_p1 [2];
  logic [1:0]       r_mode_p1 [2];
  logic             r_wp;
  logic             r_rp;
  logic [1:0]       r_level;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [1:0]       w_level_nxt;
  logic [W-1:0]     w_perm_p0;

  // Stage p0: combinational permutation of the incoming word.
  assign w_perm_p0   = permute(in_data, in_mode);

  // The handshakes use the registered flags, so a full buffer ignores
  // in_valid and an empty buffer ignores out_ready.
  assign w_in_xfer   = in_valid & r_in_ready;
  assign w_out_xfer  = r_out_valid & out_ready;
  assign w_level_nxt = r_level + {1'b0, w_in_xfer} - {1'b0, w_out_xfer};

  // Stage p1: circular buffer plus occupancy-derived flags. in_ready and
  // out_valid are computed from the next occupancy and registered, so
  // in_ready never depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_data_p1[i] <= '0;
        r_mode_p1[i] <= '0;
      end
      r_wp        <= 1'b0;
      r_rp        <= 1'b0;
      r_level     <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_in_xfer) begin
        r_data_p1[r_wp] <= w_perm_p0;
        r_mode_p1[r_wp] <= in_mode;
        r_wp            <= ~r_wp;
        r_cnt           <= r_cnt + CNT_W'(1);
      end
      if (w_out_xfer) begin
        r_rp <= ~r_rp;
      end
      r_level     <= w_level_nxt;
      r_in_ready  <= (w_level_nxt < 2'd2);
      r_out_valid <= (w_level_nxt != 2'd0);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_data_p1[r_rp];
  assign out_mode  = r_mode_p1[r_rp];
  assign level     = r_level;
  assign beat_cnt  = r_cnt;

endmodule

// File: tb/tb_bitrev_stream.sv
`timescale 1ns/1ps
// Testbench for bitrev_stream: one W=8/CNT_W=4 instance and one
// W=32/CNT_W=10 instance, driven by directed and random traffic. Input
// transfers push the reference result into a per-instance queue; monitors
// pop and compare whenever an output transfer happens.
module tb_bitrev_stream;

  logic clk;
  logic rst_n;

  logic       iv8, ir8, ov8, or8;
  logic [7:0] id8, od8;
  logic [1:0] im8, om8, lv8;
  logic [3:0] bc8;

  logic        iv32, ir32, ov32, or32;
  logic [31:0] id32, od32;
  logic [1:0]  im32, om32, lv32;
  logic [9:0]  bc32;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0]  q8  [$];
  logic [33:0] q32 [$];
  int cnt8  = 0;
  int cnt32 = 0;
  bit act8 = 0, act32 = 0, rs8 = 0, rs32 = 0;

  bitrev_stream #(.W(8), .CNT_W(4)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_mode(im8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_mode(om8),
    .level(lv8), .beat_cnt(bc8)
  );

  bitrev_stream #(.W(32), .CNT_W(10)) u32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv32), .in_ready(ir32), .in_data(id32), .in_mode(im32),
    .out_valid(ov32), .out_ready(or32), .out_data(od32), .out_mode(om32),
    .level(lv32), .beat_cnt(bc32)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference permutations written with streaming operators.
  function automatic logic [7:0] ref8(input logic [7:0] d, input logic [1:0] m);
    logic [7:0] r;
    case (m)
      2'd0: r = {<<{d}};
      2'd1: r = {<<4{d}};
      2'd2: r = {<<8{d}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref32(input logic [31:0] d, input logic [1:0] m);
    logic [31:0] r;
    case (m)
      2'd0: r = {<<{d}};
      2'd1: r = {<<4{d}};
      2'd2: r = {<<8{d}};
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    n_tests++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, x, $time);
    end
  endtask

  // Monitor / scoreboard for the 8-bit instance.
  always @(negedge clk) begin : mon8
    logic [9:0] e;
    bit can_push;
    if (act8) begin
      chk("level8",     32'(lv8), 32'(q8.size()));
      chk("out_valid8", 32'(ov8), 32'(q8.size() != 0));
      chk("in_ready8",  32'(ir8), 32'(q8.size() < 2));
      chk("beat_cnt8",  32'(bc8), 32'(cnt8 % 16));
      if (rs8) begin
        chk("rst_data8", 32'(od8), 32'd0);
        chk("rst_mode8", 32'(om8), 32'd0);
      end
    end
    rs8 = 0;
    if (!rst_n) begin
      q8.delete();
      cnt8 = 0;
      rs8  = 1;
      act8 = 1;
    end else if (act8) begin
      can_push = (q8.size() < 2);
      if (q8.size() != 0 && or8) begin
        e = q8.pop_front();
        chk("data8", 32'(od8), 32'(e[7:0]));
        chk("mode8", 32'(om8), 32'(e[9:8]));
      end
      if (iv8 && can_push) begin
        q8.push_back({im8, ref8(id8, im8)});
        cnt8++;
      end
    end
  end

  // Monitor / scoreboard for the 32-bit instance.
  always @(negedge clk) begin : mon32
    logic [33:0] e;
    bit can_push;
    if (act32) begin
      chk("level32",     32'(lv32), 32'(q32.size()));
      chk("out_valid32", 32'(ov32), 32'(q32.size() != 0));
      chk("in_ready32",  32'(ir32), 32'(q32.size() < 2));
      chk("beat_cnt32",  32'(bc32), 32'(cnt32 % 1024));
      if (rs32) begin
        chk("rst_data32", od32, 32'd0);
        chk("rst_mode32", 32'(om32), 32'd0);
      end
    end
    rs32 = 0;
    if (!rst_n) begin
      q32.delete();
      cnt32 = 0;
      rs32  = 1;
      act32 = 1;
    end else if (act32) begin
      can_push = (q32.size() < 2);
      if (q32.size() != 0 && or32) begin
        e = q32.pop_front();
        chk("data32", od32, e[31:0]);
        chk("mode32", 32'(om32), 32'(e[33:32]));
      end
      if (iv32 && can_push) begin
        q32.push_back({im32, ref32(id32, im32)});
        cnt32++;
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the beat was taken.
  task automatic put8(input logic [7:0] d, input logic [1:0] m);
    int t;
    iv8 = 1; id8 = d; im8 = m; t = 0;
    @(negedge clk);
    while (!ir8 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ir8) chk("put8_timeout", 32'(ir8), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic put32(input logic [31:0] d, input logic [1:0] m);
    int t;
    iv32 = 1; id32 = d; im32 = m; t = 0;
    @(negedge clk);
    while (!ir32 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ir32) chk("put32_timeout", 32'(ir32), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit done8, done32;
    rst_n = 0;
    iv8 = 0; id8 = '0; im8 = '0; or8 = 1;
    iv32 = 0; id32 = '0; im32 = '0; or32 = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Bit reverse on W=8, back-to-back beats.
    put8(8'b11110000, 2'd0);
    put8(8'b01000111, 2'd0);
    put8(8'b00000110, 2'd0);
    iv8 = 0;

    // Per-beat mode changes on W=32.
    put32(32'h12345678, 2'd1);
    put32(32'h12345678, 2'd2);
    put32(32'h12345678, 2'd3);
    put32(32'h12345678, 2'd0);
    iv32 = 0;
    idle(3);

    // Backpressure: third beat must wait until the consumer pops.
    or8 = 0;
    fork
      begin
        put8(8'hA5, 2'd0);
        put8(8'h3C, 2'd1);
        put8(8'h81, 2'd2);
        iv8 = 0;
      end
      begin
        idle(5);
        or8 = 1;
      end
    join
    idle(4);

    // Simultaneous push and pop at level 1.
    or32 = 0;
    put32($urandom, 2'($urandom_range(0, 3)));
    or32 = 1;
    repeat (20) put32($urandom, 2'($urandom_range(0, 3)));
    iv32 = 0;
    idle(3);

    // beat_cnt wrap on the CNT_W=4 instance.
    repeat (17) put8(8'($urandom), 2'($urandom_range(0, 3)));
    iv8 = 0;
    idle(2);

    // Random traffic with random backpressure on both instances.
    done8 = 0; done32 = 0;
    fork
      begin
        repeat (150) begin
          put8(8'($urandom), 2'($urandom_range(0, 3)));
          if ($urandom_range(0, 2) == 0) begin
            iv8 = 0;
            idle($urandom_range(1, 3));
          end
        end
        iv8 = 0;
        done8 = 1;
      end
      begin
        while (!done8) begin
          @(posedge clk);
          #1 or8 = 1'($urandom_range(0, 1));
        end
        or8 = 1;
      end
      begin
        repeat (150) begin
          put32($urandom, 2'($urandom_range(0, 3)));
          if ($urandom_range(0, 2) == 0) begin
            iv32 = 0;
            idle($urandom_range(1, 3));
          end
        end
        iv32 = 0;
        done32 = 1;
      end
      begin
        while (!done32) begin
          @(posedge clk);
          #1 or32 = 1'($urandom_range(0, 1));
        end
        or32 = 1;
      end
    join
    idle(4);

    // Reset with both buffers full, then a fresh beat.
    or8 = 0; or32 = 0;
    put8(8'h5A, 2'd1);
    put8(8'hC3, 2'd0);
    iv8 = 0;
    put32(32'hDEADBEEF, 2'd2);
    put32(32'h0F1E2D3C, 2'd0);
    iv32 = 0;
    idle(1);
    rst_n = 0;
    idle(1);
    rst_n = 1;
    or8 = 1; or32 = 1;
    put8(8'b10010110, 2'd0);
    iv8 = 0;
    put32(32'hA1B2C3D4, 2'd1);
    iv32 = 0;
    idle(5);

    chk("drain8",  32'(q8.size()),  32'd0);
    chk("drain32", 32'(q32.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bitrev_stream.md
Name: bitrev_stream

Overview:
Parametrised, handshaked successor to the team's fixed 8-bit registered bit reverser. Each input word is permuted by a per-beat mode: bit reverse, nibble reverse, byte reverse or pass-through. Results go through a 2-entry output buffer with valid/ready flow control. Sits between streaming producers and consumers, for example FFT index reordering and endianness fix-up, where backpressure must be absorbed without losing data.

Parameters:
W, 8, data width in bits; must be a multiple of 8 and at least 8.
CNT_W, 10, width of the accepted-beat counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  producer has a beat
in_ready  output  1  block can accept a beat; registered
in_data  input  W  word to permute
in_mode  input  2  permutation for this beat: 0 bit, 1 nibble, 2 byte, 3 pass
out_valid  output  1  head of buffer valid
out_ready  input  1  consumer accepts head
out_data  output  W  permuted word at head
out_mode  output  2  mode the head word was permuted with
level  output  2  buffer occupancy, 0..2
beat_cnt  output  CNT_W  number of accepted input beats, modulo 2^CNT_W

Behaviour:
- One clock domain. All state changes on the rising edge of clk.
- Reset:
  - rst_n low at an edge clears occupancy, beat_cnt, both buffer entries and read/write pointers.
  - After such an edge: out_valid=0, out_data=0, out_mode=0, level=0, beat_cnt=0, in_ready=1.
  - Reset mid-stream discards buffered beats. No output handshake completes in that cycle.
- Permutation (combinational, applied before write). For output bit j:
  - mode 0: out[j] = in[W-1-j].
  - mode 1: nibble k of out = nibble (W/4-1-k) of in; bit order inside each nibble kept.
  - mode 2: byte k of out = byte (W/8-1-k) of in; bit order inside each byte kept.
  - mode 3: out = in.
- Handshakes:
  - Input transfer when in_valid && in_ready at an edge. Output transfer when out_valid && out_ready at an edge.
  - Producer may change in_data/in_mode freely while in_valid=0.
  - out_data/out_mode hold stable while out_valid=1 and out_ready=0.
- Buffer: 2-entry circular buffer with 1-bit write and read pointers, each wrapping 1 to 0.
  - Write stores the permuted word plus in_mode. The mode used is the one sampled with that beat; per-beat mode changes are legal back to back.
- Latency: a beat accepted at edge N appears on out_data with out_valid=1 from edge N onwards, when the buffer was empty. Throughput is one beat per cycle with out_ready held high.
- Occupancy: level_next = level + in_xfer - out_xfer.
  - Simultaneous in and out transfers leave level unchanged. Both pointers advance.
  - in_ready = (level_next < 2), registered. in_ready is not combinationally dependent on out_ready.
  - Full (level=2): in_ready=0; in_valid is ignored.
  - Empty (level=0): out_valid=0; out_ready is ignored.
  - Sequence from full: full, consumer pops, in_ready rises the following cycle.
- out_valid = (level != 0), registered. out_data/out_mode read the entry at the read pointer.
- beat_cnt increments by 1 on every input transfer and wraps from 2^CNT_W-1 to 0 with no flag.
- Illegal W (not a multiple of 8) is not supported. The bench tests only W=8 and W=32.

Test Plan:
- W=8, mode 0, out_ready=1: send 8'b11110000, 8'b01000111, 8'b00000110 on consecutive edges -> out_data 8'b00001111, 8'b11100010, 8'b01100000, each visible one edge after acceptance, level ≤1.
- W=32, modes 1/2/3 per beat on 32'h12345678:
  - mode 1 -> 32'h87654321
  - mode 2 -> 32'h78563412
  - mode 3 -> 32'h12345678
  - out_mode tracks each beat.
- Backpressure: out_ready=0, drive 3 beats -> first two accepted, level=2, in_ready=0 after second acceptance, third held. Raise out_ready -> third accepted one cycle later; output order preserved, no loss or duplication.
- Simultaneous push/pop at level=1 for 20 cycles -> level stays 1; out_data stream equals input stream permuted and delayed one beat.
- beat_cnt wrap with CNT_W=4: accept 17 beats -> beat_cnt reads 15 then 0 then 1.
- Reset mid-stream at level=2: rst_n=0 for one edge -> next cycle out_valid=0, level=0, beat_cnt=0, in_ready=1, out_data=0. Fresh beat after reset emerges correctly.
